// File: rtl/sr_drive_sequencer.sv
// sr_drive_sequencer
//
// Drives the S/R inputs of a downstream master-slave SR flip-flop. A command
// accepted over the Req/Busy/Done handshake holds S or R high for
// PULSE_CYCLES cycles, releases both for SETTLE_CYCLES cycles, then compares
// the flip-flop's Q/Qbar feedback against the value the command should have
// produced. S and R are never high together.
//
// Parameters:
//   PULSE_CYCLES   cycles S or R is held high per command (1..255)
//   SETTLE_CYCLES  cycles with S=R=0 before feedback is checked (1..255)
//
// Ports:
//   C        clock, all state changes on the rising edge
//   Reset    asynchronous active-high reset
//   Req      command request, only looked at while idle
//   Op       command: 00 hold, 01 set, 10 reset, 11 toggle
//   Q_fb     Q from the downstream flip-flop
//   Qbar_fb  Qbar from the downstream flip-flop
//   S, R     registered set/reset drive to the flip-flop
//   Busy     high whenever a command is in progress
//   Done     one-cycle pulse when a command completes
//   Err      result of the last feedback check, held until the next accept
//   Count    number of completed commands, wraps 255 -> 0

module sr_drive_sequencer #(
  parameter int unsigned PULSE_CYCLES  = 2,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       C,
  input  logic       Reset,
  input  logic       Req,
  input  logic [1:0] Op,
  input  logic       Q_fb,
  input  logic       Qbar_fb,
  output logic       S,
  output logic       R,
  output logic       Busy,
  output logic       Done,
  output logic       Err,
  output logic [7:0] Count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    RELEASE = 2'd2,
    CHECK   = 2'd3
  } state_t;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_RESET  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  // Phase counters are loaded with length-1 so that a phase ends on the edge
  // where the counter already reads zero.
  localparam logic [7:0] PULSE_LOAD  = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state;
  logic       exp_q;
  logic [7:0] phase_cnt;

  // Single-process FSM: every output is a register written alongside the
  // state, so nothing reaches an output combinationally. S and R are only
  // ever written as a complementary pair on entry to DRIVE and cleared
  // together on leaving it, which keeps S&R at 0 in every state. Feedback is
  // sampled on the edge that enters CHECK so that Err and Count are already
  // valid in the same cycle that Done is high.
  always_ff @(posedge C or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      S         <= 1'b0;
      R         <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Err       <= 1'b0;
      Count     <= 8'd0;
      exp_q     <= 1'b0;
      phase_cnt <= 8'd0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Req) begin
            Busy <= 1'b1;
            Err  <= 1'b0;
            case (Op)
              OP_SET: begin
                exp_q     <= 1'b1;
                S         <= 1'b1;
                R         <= 1'b0;
                phase_cnt <= PULSE_LOAD;
                state     <= DRIVE;
              end
              OP_RESET: begin
                exp_q     <= 1'b0;
                S         <= 1'b0;
                R         <= 1'b1;
                phase_cnt <= PULSE_LOAD;
                state     <= DRIVE;
              end
              OP_TOGGLE: begin
                // Toggle resolves to a plain set or reset from current Q.
                exp_q     <= ~Q_fb;
                S         <= ~Q_fb;
                R         <= Q_fb;
                phase_cnt <= PULSE_LOAD;
                state     <= DRIVE;
              end
              default: begin
                // Hold skips the drive phase entirely.
                exp_q     <= Q_fb;
                S         <= 1'b0;
                R         <= 1'b0;
                phase_cnt <= SETTLE_LOAD;
                state     <= RELEASE;
              end
            endcase
          end
        end
        DRIVE: begin
          if (phase_cnt == 8'd0) begin
            S         <= 1'b0;
            R         <= 1'b0;
            phase_cnt <= SETTLE_LOAD;
            state     <= RELEASE;
          end else begin
            phase_cnt <= phase_cnt - 8'd1;
          end
        end
        RELEASE: begin
          if (phase_cnt == 8'd0) begin
            Done  <= 1'b1;
            Err   <= (Q_fb != exp_q) || (Qbar_fb == Q_fb);
            Count <= Count + 8'd1;
            state <= CHECK;
          end else begin
            phase_cnt <= phase_cnt - 8'd1;
          end
        end
        CHECK: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          S     <= 1'b0;
          R     <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sr_drive_sequencer.md
# sr_drive_sequencer

Request-driven sequencer that drives the S/R inputs of the master-slave SR flip-flop built from the gated SR latch stage. It sits directly upstream of that flip-flop: it accepts set/reset/hold/toggle commands over a Req/Busy/Done handshake, holds S or R for a programmable number of cycles, and releases both to 0. It then checks the flip-flop's Q/Qbar feedback against the expected value. It guarantees that S and R are never asserted together.

## Interface
- PULSE_CYCLES, 2, cycles S or R is held high per command (1..255)
- SETTLE_CYCLES, 2, cycles S=R=0 before feedback is checked (1..255)

- C  in  1  clock, all state on rising edge
- Reset  in  1  asynchronous, active-high reset
- Req  in  1  command request, sampled only in IDLE
- Op  in  2  command: 00 hold, 01 set, 10 reset, 11 toggle
- Q_fb  in  1  Q from downstream flip-flop
- Qbar_fb  in  1  Qbar from downstream flip-flop
- S  out  1  set drive to flip-flop
- R  out  1  reset drive to flip-flop
- Busy  out  1  high in every state except IDLE
- Done  out  1  one-cycle pulse, command complete
- Err  out  1  result of last check, valid from Done until next accept
- Count  out  8  completed commands, wraps 255->0

## Operation
- Reset (async, any state): state IDLE, S=0, R=0, Busy=0, Done=0, Err=0, Count=0, internal counters 0.
- States are IDLE, DRIVE, RELEASE, and CHECK.
- IDLE: on an edge with Req=1, latch Op and compute the expected value Exp.
  - Set: Exp=1.
  - Reset: Exp=0.
  - Hold: Exp=Q_fb.
  - Toggle: Exp=~Q_fb.
  - Clear Err.
  - Next state is DRIVE for set/reset/toggle and RELEASE for hold.
- DRIVE: S=Exp, R=~Exp. This applies to toggle as well, which resolves to set when Q was 0 and to reset when Q was 1.
  - Stay exactly PULSE_CYCLES cycles, then go to RELEASE.
- RELEASE: S=R=0 for exactly SETTLE_CYCLES cycles, then go to CHECK.
- CHECK: one cycle with Done=1.
  - Err is set if Q_fb!=Exp or Qbar_fb==Q_fb.
  - Count increments modulo 256.
  - Next state is IDLE.
- S and R are registered and decoded from state. S&R=1 is illegal and must never occur, including across reset and state changes.
- Req while Busy=1 is ignored, not queued. Op changes while Busy have no effect.
- Req held high continuously starts a new command on the edge following CHECK (back-to-back). No idle gap is required beyond the IDLE cycle.
- Err stays at its CHECK value until the next accepted command clears it.
- Reset asserted mid-DRIVE drops S/R to 0 immediately (asynchronously) and aborts the command. No Done, no Count change.

## Timing
- Accept edge = e0, the edge with IDLE and Req=1.
- After e0, Busy=1.
- Set/reset/toggle:
  - S or R is high after e0 through e0+PULSE_CYCLES.
  - Both are 0 after e0+PULSE_CYCLES.
  - CHECK/Done is high after e0+PULSE_CYCLES+SETTLE_CYCLES.
  - IDLE is reached after the following edge.
- Hold: CHECK/Done after e0+SETTLE_CYCLES.
- Defaults, set/reset/toggle: Done in cycle 5 after e0, Busy high for 5 cycles, minimum command period 6 cycles.
- Feedback Q_fb/Qbar_fb is sampled only in the CHECK cycle (and at accept for hold/toggle). Feedback must settle within SETTLE_CYCLES.
- No combinational path from any input to any output.

## Test plan
- Reset during traffic: assert Reset in DRIVE of a set -> S,R,Busy,Done,Err,Count all 0 within the same cycle; no Done appears afterward.
- Set, defaults, Q_fb/Qbar_fb model a correct flip-flop (Q=0 initially):
  - Req=1, Op=01 at e0 -> S=1 for 2 cycles, then S=R=0 for 2 cycles.
  - Done=1 in cycle 5, Err=0, Count=1.
  - S&R never 1.
- Toggle twice back-to-back, Req held high, Q starting at 1:
  - First command drives R, Exp=0.
  - Second command drives S, Exp=1.
  - Done pulses 6 cycles apart, Err=0, Count=2.
- Fault injection: Op=01 with the model stuck at Q_fb=0, Qbar_fb=1 -> Err=1 at Done and held until the next accept. Then a hold command from that state -> Err cleared, Done after SETTLE_CYCLES, Err=0.
- Illegal feedback: Q_fb=Qbar_fb=1 during CHECK of a reset command -> Err=1. Req pulses during Busy -> ignored, Count increments once only.
- Wrap and parameters:
  - 256 hold commands -> Count returns to 0.
  - Rerun the set test with PULSE_CYCLES=1, SETTLE_CYCLES=3 -> S high 1 cycle, Done in cycle 5.
